// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control unit: sequences fetch, decode, execute, memory
// and writeback steps, handshaking with memory and flagging faults.
module mc_control_fsm #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       illegal_op,
    output logic       mem_fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC_R = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        EXEC_I = 4'd11,
        IMMWB  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           cur_state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic [5:0]       op_q;
    logic             waiting;
    logic             timeout;
    logic             decode_illegal;
    logic             zero_unused;

    // The branch condition is resolved in the datapath, not here.
    assign zero_unused = Zero;

    assign waiting = (cur_state == FETCH) || (cur_state == MEMRD) || (cur_state == MEMWR);
    assign timeout = waiting && !mem_ready && (wait_cnt == CNT_LIMIT);
    assign state   = cur_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= IDLE;
            wait_cnt   <= '0;
            op_q       <= '0;
            illegal_op <= 1'b0;
            mem_fault  <= 1'b0;
        end else begin
            cur_state  <= next_state;
            wait_cnt   <= wait_cnt_next;
            illegal_op <= decode_illegal;
            mem_fault  <= mem_fault | timeout;
            if (cur_state == DECODE) begin
                op_q <= Opcode;
            end
        end
    end

    always_comb begin
        wait_cnt_next = '0;
        if (waiting && (next_state == cur_state) && !mem_ready) begin
            wait_cnt_next = wait_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state     = cur_state;
        decode_illegal = 1'b0;
        case (cur_state)
            IDLE:   next_state = FETCH;
            FETCH: begin
                if (timeout) begin
                    next_state = IDLE;
                end else if (mem_ready) begin
                    next_state = DECODE;
                end
            end
            DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW:             next_state = MEMADR;
                    OP_RTYPE:                 next_state = EXEC_R;
                    OP_BEQ:                   next_state = BRANCH;
                    OP_J:                     next_state = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: next_state = EXEC_I;
                    default: begin
                        next_state     = FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: next_state = (op_q == OP_SW) ? MEMWR : MEMRD;
            MEMRD: begin
                if (timeout) begin
                    next_state = IDLE;
                end else if (mem_ready) begin
                    next_state = MEMWB;
                end
            end
            MEMWB:  next_state = FETCH;
            MEMWR: begin
                if (timeout) begin
                    next_state = IDLE;
                end else if (mem_ready) begin
                    next_state = FETCH;
                end
            end
            EXEC_R: next_state = ALUWB;
            ALUWB:  next_state = FETCH;
            BRANCH: next_state = FETCH;
            JUMP:   next_state = FETCH;
            EXEC_I: next_state = IMMWB;
            IMMWB:  next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Memory strobes are withdrawn in the timeout cycle so the bus sees no request.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        case (cur_state)
            FETCH: begin
                MemRead = !timeout;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                ALUSrcB = 2'b01;
            end
            DECODE: ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = !timeout;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = !timeout;
                IorD     = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (op_q)
                    OP_ANDI: ALUOp = 3'b100;
                    OP_ORI:  ALUOp = 3'b101;
                    default: ALUOp = 3'b011;
                endcase
            end
            IMMWB:  RegWrite = 1'b1;
            default: ;
        endcase
    end

endmodule
